// File: rtl/des_key_scheduler.sv
// des_key_scheduler: steps the DES C||D key register once per round and emits PC-2 subkeys over valid/ready.
// Build option: define DES_DECRYPT_EN to add the decrypt port (reverse-order schedule K16..K1).
module des_key_scheduler #(
    parameter int KEY_W    = 56,
    parameter int SUBKEY_W = 48,
    parameter int ROUNDS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_W-1:0]    key_in,
`ifdef DES_DECRYPT_EN
    input  logic                decrypt,
`endif
    input  logic                key_ready,
    output logic [SUBKEY_W-1:0] round_key,
    output logic [4:0]          round_idx,
    output logic                key_valid,
    output logic                busy,
    output logic                done
);

    localparam int         HALF = KEY_W / 2;
    localparam logic [4:0] LAST = 5'(ROUNDS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [KEY_W-1:0] cd, cd_next;
    logic [4:0]       idx_next;
    logic             done_next;
    logic             reverse, reverse_next;
    logic             rev_start;
    logic             transfer;

    function automatic logic single_shift(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    // Both 28-bit halves rotate independently; bits leaving one end re-enter at the other.
    function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] x, input logic one);
        logic [HALF-1:0] hi;
        logic [HALF-1:0] lo;
        hi = x[KEY_W-1:HALF];
        lo = x[HALF-1:0];
        if (one) begin
            hi = {hi[HALF-2:0], hi[HALF-1]};
            lo = {lo[HALF-2:0], lo[HALF-1]};
        end else begin
            hi = {hi[HALF-3:0], hi[HALF-1:HALF-2]};
            lo = {lo[HALF-3:0], lo[HALF-1:HALF-2]};
        end
        return {hi, lo};
    endfunction

    function automatic logic [KEY_W-1:0] rotr(input logic [KEY_W-1:0] x, input logic one);
        logic [HALF-1:0] hi;
        logic [HALF-1:0] lo;
        hi = x[KEY_W-1:HALF];
        lo = x[HALF-1:0];
        if (one) begin
            hi = {hi[0], hi[HALF-1:1]};
            lo = {lo[0], lo[HALF-1:1]};
        end else begin
            hi = {hi[1:0], hi[HALF-1:2]};
            lo = {lo[1:0], lo[HALF-1:2]};
        end
        return {hi, lo};
    endfunction

    // Standard PC-2 table; table bit n (1 = leftmost) is k[56-n].
    function automatic logic [SUBKEY_W-1:0] pc2(input logic [KEY_W-1:0] k);
        return {k[42], k[39], k[45], k[32], k[55], k[51],
                k[53], k[28], k[41], k[50], k[35], k[46],
                k[33], k[37], k[44], k[52], k[30], k[48],
                k[40], k[49], k[29], k[36], k[43], k[54],
                k[15], k[4],  k[25], k[19], k[9],  k[1],
                k[26], k[16], k[5],  k[11], k[23], k[8],
                k[12], k[7],  k[17], k[0],  k[22], k[3],
                k[10], k[14], k[6],  k[20], k[27], k[24]};
    endfunction

`ifdef DES_DECRYPT_EN
    assign rev_start = decrypt;
`else
    assign rev_start = 1'b0;
`endif

    assign key_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign transfer  = key_valid & key_ready;
    assign round_key = pc2(cd);

    always_comb begin
        state_next   = state;
        cd_next      = cd;
        idx_next     = round_idx;
        done_next    = 1'b0;
        reverse_next = reverse;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = RUN;
                    reverse_next = rev_start;
                    // Decrypt starts at K16, whose C||D equals the loaded key (total shift is 28).
                    if (rev_start) begin
                        cd_next  = key_in;
                        idx_next = LAST;
                    end else begin
                        cd_next  = rotl(key_in, 1'b1);
                        idx_next = 5'd1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (transfer) begin
                    if (round_idx == (reverse ? 5'd1 : LAST)) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        done_next  = 1'b1;
                    end else if (reverse) begin
                        cd_next  = rotr(cd, single_shift(round_idx));
                        idx_next = round_idx - 5'd1;
                    end else begin
                        cd_next  = rotl(cd, single_shift(round_idx + 5'd1));
                        idx_next = round_idx + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cd        <= '0;
            round_idx <= '0;
            done      <= 1'b0;
            reverse   <= 1'b0;
        end else begin
            state     <= state_next;
            cd        <= cd_next;
            round_idx <= idx_next;
            done      <= done_next;
            reverse   <= reverse_next;
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: known-answer table, scoreboard of expected subkeys, corner-case sequences.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [55:0] key_in;
    logic        decrypt;
    logic        key_ready;
    logic [47:0] round_key;
    logic [4:0]  round_idx;
    logic        key_valid;
    logic        busy;
    logic        done;

    des_key_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .key_in    (key_in),
`ifdef DES_DECRYPT_EN
        .decrypt   (decrypt),
`endif
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef struct {
        logic [55:0] key;
        logic [4:0]  idx;
        logic [47:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [47:0] key;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[3];
    logic [47:0] got[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: apply the cumulative left-shift one bit at a time, then PC-2 by table lookup.
    function automatic logic [47:0] ref_key(input logic [55:0] k, input int r);
        int          s;
        logic [27:0] hi;
        logic [27:0] lo;
        logic [55:0] c;
        logic [47:0] o;
        s  = 0;
        hi = k[55:28];
        lo = k[27:0];
        for (int j = 1; j <= r; j++) s += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
        for (int j = 0; j < s; j++) begin
            hi = {hi[26:0], hi[27]};
            lo = {lo[26:0], lo[27]};
        end
        c = {hi, lo};
        for (int i = 0; i < 48; i++) o[47-i] = c[56-PC2[i]];
        return o;
    endfunction

    task automatic push_sched(input logic [55:0] k, input bit dec);
        exp_t e;
        for (int n = 1; n <= 16; n++) begin
            e.idx = dec ? 5'(17 - n) : 5'(n);
            e.key = ref_key(k, int'(e.idx));
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sched(input logic [55:0] k, input bit dec);
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        push_sched(k, dec);
        tick();
        start   = 1'b0;
        decrypt = 1'b0;
    endtask

    task automatic run_until_done(input bit rnd, input int bound);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            if (rnd) key_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", bound);
        end
        key_ready = 1'b1;
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic advance_to(input logic [4:0] target);
        for (int c = 0; c < 40 && round_idx != target; c++) tick();
        check("reach_idx", 64'(round_idx), 64'(target));
    endtask

    // Scoreboard monitor: pops one expectation per accepted key and checks stall stability.
    logic        stall_q = 1'b0;
    logic [47:0] key_q;
    logic [4:0]  idx_q;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && key_valid) begin
            if (stall_q) begin
                check("stall_key", 64'(round_key), 64'(key_q));
                check("stall_idx", 64'(round_idx), 64'(idx_q));
            end
            if (key_ready && !abort) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got idx %0d key %h, expected no transfer", round_idx, round_key);
                end else begin
                    e = sb.pop_front();
                    check("sb_idx", 64'(round_idx), 64'(e.idx));
                    check("sb_key", 64'(round_key), 64'(e.key));
                end
            end
        end
        stall_q = !rst && key_valid && !key_ready && !abort;
        key_q   = round_key;
        idx_q   = round_idx;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [55:0] rk;
        vecs[0] = '{KEY_A, 5'd1,  48'h1B02EFFC7072};
        vecs[1] = '{KEY_A, 5'd2,  48'h79AED9DBC9E5};
        vecs[2] = '{KEY_A, 5'd16, 48'hCB3D8B0E17F5};

        rst = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b0; key_in = '0; decrypt = 1'b0;
        #12;
        check("rst_valid", 64'(key_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_idx",   64'(round_idx), 64'd0);
        check("rst_key",   64'(round_key), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Known-answer run with key_ready held high; latency and done timing checked per cycle.
        key_ready = 1'b1;
        begin_sched(KEY_A, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            check("t1_valid", 64'(key_valid), 64'd1);
            check("t1_busy",  64'(busy),      64'd1);
            check("t1_idx",   64'(round_idx), 64'(i));
            got[i] = round_key;
            tick();
        end
        check("t1_done",      64'(done),      64'd1);
        check("t1_end_valid", 64'(key_valid), 64'd0);
        check("t1_end_busy",  64'(busy),      64'd0);
        check("t1_end_idx",   64'(round_idx), 64'd0);
        for (int v = 0; v < 3; v++) check("kat", 64'(got[vecs[v].idx]), 64'(vecs[v].exp));

        // start during the done cycle is accepted.
        begin_sched(KEY_A, 1'b0);
        check("t6_valid", 64'(key_valid), 64'd1);
        check("t6_idx",   64'(round_idx), 64'd1);
        check("t6_key",   64'(round_key), 64'(vecs[0].exp));
        check("t6_done",  64'(done),      64'd0);
        run_until_done(1'b0, 40);

        // Random back-pressure, known key then a random key.
        tick();
        begin_sched(KEY_A, 1'b0);
        run_until_done(1'b1, 300);
        tick();
        rk = {24'($urandom), 32'($urandom)};
        begin_sched(rk, 1'b0);
        run_until_done(1'b1, 300);
        tick();

        // Abort at round 7 beats a simultaneous transfer; no done follows.
        begin_sched(KEY_A, 1'b0);
        advance_to(5'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        check("t3_valid", 64'(key_valid), 64'd0);
        check("t3_busy",  64'(busy),      64'd0);
        for (int c = 0; c < 3; c++) begin
            check("t3_no_done", 64'(done), 64'd0);
            tick();
        end
        abort = 1'b1;
        begin_sched(KEY_A, 1'b0);
        abort = 1'b0;
        check("t3_restart_idx", 64'(round_idx), 64'd1);
        check("t3_restart_key", 64'(round_key), 64'(vecs[0].exp));
        run_until_done(1'b0, 40);
        tick();

        // Asynchronous reset in the middle of a schedule.
        begin_sched(KEY_A, 1'b0);
        advance_to(5'd10);
        rst = 1'b1;
        #1;
        check("t4_valid", 64'(key_valid), 64'd0);
        check("t4_busy",  64'(busy),      64'd0);
        check("t4_idx",   64'(round_idx), 64'd0);
        check("t4_key",   64'(round_key), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        check("t4_no_done", 64'(done), 64'd0);
        tick();

        // start while busy is ignored; the original key keeps going.
        rk = {24'($urandom), 32'($urandom)};
        begin_sched(rk, 1'b0);
        advance_to(5'd4);
        key_in = ~rk;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t4_idx_cont", 64'(round_idx), 64'd5);
        check("t4_busy_run", 64'(busy),      64'd1);
        run_until_done(1'b0, 40);
        tick();

`ifdef DES_DECRYPT_EN
        begin_sched(KEY_A, 1'b1);
        check("t5_first_idx", 64'(round_idx), 64'd16);
        check("t5_first_key", 64'(round_key), 64'(vecs[2].exp));
        advance_to(5'd1);
        check("t5_last_key", 64'(round_key), 64'(vecs[0].exp));
        run_until_done(1'b0, 10);
        tick();
        begin_sched(KEY_A, 1'b1);
        run_until_done(1'b1, 300);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
